// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential word fetches, buffers responses in a
// prefetch FIFO and presents {INST, inst_pc} to the core; a redirect flushes and drops in-flight words.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] INST,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [31:0]     r_fifo_data [DEPTH];
    logic [31:0]     r_fifo_pc   [DEPTH];
    logic [31:0]     r_ifq_pc    [DEPTH];
    logic [AW-1:0]   r_ifq_wr;
    logic [AW-1:0]   r_ifq_rd;

    logic            w_req_fire;
    logic            w_rsp_cnt;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [CW:0]     w_occupancy;
    logic [31:0]     w_redirect_pc;

    // Requests are only raised when every possible response already has a FIFO slot reserved.
    assign w_occupancy       = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid    = (r_state == ST_FETCH) && (w_occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr     = r_fetch_pc;
    assign w_req_fire        = imem_req_valid & imem_req_ready;
    assign w_rsp_cnt         = imem_rsp_valid & (r_outstanding != {CW{1'b0}});
    assign w_push            = w_rsp_cnt & (r_drop_cnt == {CW{1'b0}}) & ~redirect;
    assign w_pop             = inst_valid & inst_ready & ~redirect;
    assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_cnt);
    assign w_redirect_pc     = redirect_pc & 32'hFFFF_FFFC;

    assign inst_valid = (r_count != {CW{1'b0}});
    assign INST       = r_fifo_data[r_rd_ptr];
    assign inst_pc    = r_fifo_pc[r_rd_ptr];

    // Next-state and drop-counter logic; a redirect overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        if (redirect) begin
            w_drop_nxt  = w_outstanding_nxt;
            w_state_nxt = (w_outstanding_nxt != {CW{1'b0}}) ? ST_FLUSH : ST_FETCH;
        end else begin
            if (w_rsp_cnt && (r_drop_cnt != {CW{1'b0}})) begin
                w_drop_nxt = r_drop_cnt - CW'(1);
            end else begin
                w_drop_nxt = r_drop_cnt;
            end
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_FETCH;
                ST_FETCH: w_state_nxt = ST_FETCH;
                ST_FLUSH: w_state_nxt = (w_drop_nxt == {CW{1'b0}}) ? ST_FETCH : ST_FLUSH;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= {CW{1'b0}};
            r_drop_cnt    <= {CW{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_nxt;
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
        end
    end

    // In-flight PC queue pops on every counted response, dropped or not, to stay aligned with memory.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_ifq_wr <= {AW{1'b0}};
            r_ifq_rd <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_ifq_pc[i] <= 32'd0;
            end
        end else begin
            if (w_req_fire) begin
                r_ifq_pc[r_ifq_wr] <= r_fetch_pc;
                r_ifq_wr           <= r_ifq_wr + AW'(1);
            end
            if (w_rsp_cnt) begin
                r_ifq_rd <= r_ifq_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= 32'd0;
                r_fifo_pc[i]   <= 32'd0;
            end
        end else if (redirect) begin
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= imem_rsp_data;
                r_fifo_pc[r_wr_ptr]   <= r_ifq_pc[r_ifq_rd];
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule
